// File: rtl/exec_trace_buffer_if.sv
// Trace drain bus between exec_trace_buffer and a debug host.
//   master (buffer): drives TraceValid and the head entry (TracePC/TraceInstr/TraceALU),
//                    samples TraceReady.
//   slave  (host)  : samples the head entry, drives TraceReady.
// An entry is transferred on a rising edge where TraceValid && TraceReady.
interface exec_trace_buffer_if;
  logic        TraceValid;
  logic        TraceReady;
  logic [31:0] TracePC;
  logic [31:0] TraceInstr;
  logic [31:0] TraceALU;

  modport master (
    output TraceValid,
    output TracePC,
    output TraceInstr,
    output TraceALU,
    input  TraceReady
  );

  modport slave (
    input  TraceValid,
    input  TracePC,
    input  TraceInstr,
    input  TraceALU,
    output TraceReady
  );
endinterface

// File: rtl/exec_trace_buffer.sv
// Execution-trace capture FIFO placed downstream of the single-cycle core.
// Once armed, the first cycle whose PC equals TrigPC starts a window of CAPTURE_LEN consecutive
// (PC, Instr, ALUResult) samples. Samples are queued in a DEPTH-entry FIFO and drained to a
// debug host over the trace interface.
// Ports:
//   CLK, RST       clock; synchronous active-low reset
//   Arm            one-cycle arm / re-arm request (honoured in IDLE and DONE only)
//   TrigPC         PC value that opens the capture window
//   PC/Instr/ALUResult  core debug outputs, sampled every cycle
//   trace          drain bus (master side): head entry + valid/ready
//   Count          entries held, 0..DEPTH
//   State          0=IDLE 1=ARMED 2=CAPTURE 3=DONE
//   Overflow       sticky: a sample was dropped because the FIFO was full
//   Done           high while State==DONE
module exec_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CAPTURE_LEN = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Arm,
  input  logic [31:0]               TrigPC,
  input  logic [31:0]               PC,
  input  logic [31:0]               Instr,
  input  logic [31:0]               ALUResult,
  exec_trace_buffer_if.master       trace,
  output logic [$clog2(DEPTH):0]    Count,
  output logic [1:0]                State,
  output logic                      Overflow,
  output logic                      Done
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam int unsigned CapW   = $clog2(CAPTURE_LEN + 1);

  localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);
  localparam logic [CapW-1:0]   CapLast   = CapW'(CAPTURE_LEN);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [CapW-1:0]   cap_cnt_q;
  logic              overflow_q;

  logic [31:0] mem_pc_q    [DEPTH];
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_alu_q   [DEPTH];

  logic valid, full, push, pop, push_ok;

  always_comb begin
    valid   = (count_q != '0);
    full    = (count_q == CountFull);
    push    = ((state_q == StArmed) && (PC == TrigPC)) || (state_q == StCapture);
    pop     = valid && trace.TraceReady;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = push && (!full || pop);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Arm) begin
            state_q    <= StArmed;
            overflow_q <= 1'b0;
            cap_cnt_q  <= '0;
          end
        end
        StArmed: begin
          if (PC == TrigPC) begin
            cap_cnt_q <= CapW'(1);
            state_q   <= (CAPTURE_LEN == 1) ? StDone : StCapture;
          end
        end
        StCapture: begin
          // Counter advances even when the sample is dropped, so the window length is fixed.
          cap_cnt_q <= cap_cnt_q + CapW'(1);
          if (cap_cnt_q == CapLast - CapW'(1)) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase

      // Pushes only happen in ARMED/CAPTURE, so this never collides with the arm-time clear.
      if (push && !push_ok) overflow_q <= 1'b1;

      if (push_ok) begin
        mem_pc_q[wr_ptr_q]    <= PC;
        mem_instr_q[wr_ptr_q] <= Instr;
        mem_alu_q[wr_ptr_q]   <= ALUResult;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end

      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);

      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head data is forced to zero when empty so stale entries never leak onto the bus.
  always_comb begin
    trace.TraceValid = valid;
    trace.TracePC    = valid ? mem_pc_q[rd_ptr_q]    : '0;
    trace.TraceInstr = valid ? mem_instr_q[rd_ptr_q] : '0;
    trace.TraceALU   = valid ? mem_alu_q[rd_ptr_q]   : '0;
    Count            = count_q;
    State            = state_q;
    Overflow         = overflow_q;
    Done             = (state_q == StDone);
  end

endmodule
